pwm_deadtime: RTL

//   Downstream stage of the selectable-duty PWM generator. Converts its single
//   PWM OUTPUT into complementary high-side/low-side gate drives (half-bridge)

---
 rtl/pwm_deadtime.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pwm_deadtime.sv
// pwm_deadtime
//   Converts a single PWM waveform into complementary high-side / low-side
//   gate drives for a half-bridge, inserting a programmable dead band on
//   every transition so both switches are never on together.
//
//   Optional feature macro: PWM_DT_FAULT_EN
//     When defined, adds a fault input that forces both drives off and
//     latches a fault flag until enable is dropped.
//
// Ports
//   clk           in   1         system clock, rising edge
//   rst           in   1         synchronous active-high reset
//   enable        in   1         1 = drive outputs, 0 = both off
//   pwm_in        in   1         PWM waveform from the PWM generator
//   dt_cycles     in   DT_WIDTH  dead time in clk cycles (0 behaves as 1)
//   fault         in   1         (PWM_DT_FAULT_EN) force off and latch
//   fault_latched out  1         (PWM_DT_FAULT_EN) latched fault flag
//   out_hi        out  1         high-side gate drive
//   out_lo        out  1         low-side gate drive
//   dt_active     out  1         1 while in the dead band
module pwm_deadtime #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                pwm_in,
  input  logic [DT_WIDTH-1:0] dt_cycles,
`ifdef PWM_DT_FAULT_EN
  input  logic                fault,
  output logic                fault_latched,
`endif
  output logic                out_hi,
  output logic                out_lo,
  output logic                dt_active
);

`ifdef PWM_DT_FAULT_EN
  typedef enum logic [2:0] {IDLE, DEAD, HI, LO, FAULTED} state_t;
`else
  typedef enum logic [1:0] {IDLE, DEAD, HI, LO} state_t;
`endif

  state_t              state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                pwm_q;

  // Counter load value for a dead band of max(dt,1) cycles: the DEAD state
  // is held for load+1 cycles, so load = dt_eff - 1 (0 for dt of 0 or 1).
  function automatic logic [DT_WIDTH-1:0] dead_load(input logic [DT_WIDTH-1:0] dt);
    if (dt == '0) return '0;
    else          return dt - DT_WIDTH'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef PWM_DT_FAULT_EN
    if (fault) begin
      state_d = FAULTED;
      cnt_d   = '0;
    end else
`endif
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DEAD;
          cnt_d   = dead_load(dt_cycles);
        end
        DEAD: begin
          // Exit follows the current pwm_q, so a pulse shorter than the
          // dead band is swallowed without a second band.
          if (cnt_q != '0) cnt_d = cnt_q - DT_WIDTH'(1);
          else             state_d = pwm_q ? HI : LO;
        end
        HI: begin
          if (!pwm_q) begin
            state_d = DEAD;
            cnt_d   = dead_load(dt_cycles);
          end
        end
        LO: begin
          if (pwm_q) begin
            state_d = DEAD;
            cnt_d   = dead_load(dt_cycles);
          end
        end
`ifdef PWM_DT_FAULT_EN
        FAULTED: state_d = FAULTED;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Input stage, state register and registered output decode. Outputs are
  // decoded from the next state into flops so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q         <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      out_hi        <= 1'b0;
      out_lo        <= 1'b0;
      dt_active     <= 1'b0;
`ifdef PWM_DT_FAULT_EN
      fault_latched <= 1'b0;
`endif
    end else begin
      pwm_q         <= pwm_in;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_hi        <= (state_d == HI);
      out_lo        <= (state_d == LO);
      dt_active     <= (state_d == DEAD);
`ifdef PWM_DT_FAULT_EN
      fault_latched <= (state_d == FAULTED);
`endif
    end
  end

endmodule
